mb_echo_delay: RTL and testbench

- Sample-rate echo/delay effect on the PCM effects chain.
- Inserted between ring_modulator output and the mb_pcm_to_pwm pair; runs in the clk_pdm domain.
- Stores past samples in an inferred BRAM ring buffer and reads back the sample from delay_len samples ago.
- Mixes the delayed sample into the output (wet gain) and back into the buffer (feedback gain), with saturation. Emits one output strobe per accepted input sample.

---
 rtl/mb_audio_pkg.sv | 35 +++
 rtl/mb_sdp_bram.sv | 24 ++
 rtl/mb_echo_delay.sv | 118 +++++++++++
 tb/tb_mb_echo_delay.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mb_audio_pkg.sv
// Shared PCM constants, saturation helper and echo-delay types for the audio effects chain.
package mb_audio_pkg;

    localparam int PCM_W = 16;
    localparam logic signed [PCM_W-1:0] PCM_MAX = 16'sh7FFF;
    localparam logic signed [PCM_W-1:0] PCM_MIN = 16'sh8000;
    localparam logic signed [17:0]      SAT_HI  = 18'sd32767;
    localparam logic signed [17:0]      SAT_LO  = -18'sd32768;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_READ,
        ST_CALC,
        ST_WRITE
    } echo_state_t;

    // Per-sample context captured at acceptance; later input changes cannot leak in.
    typedef struct packed {
        logic signed [PCM_W-1:0] x;
        logic                    en;
        logic [2:0]              fb;
        logic [2:0]              wet;
    } echo_ctx_t;

    function automatic logic signed [PCM_W-1:0] pcm_sat(input logic signed [17:0] v);
        if (v > SAT_HI)
            return PCM_MAX;
        else if (v < SAT_LO)
            return PCM_MIN;
        else
            return v[PCM_W-1:0];
    endfunction

endpackage

// File: rtl/mb_sdp_bram.sv
// Simple dual-port RAM: one write port, one registered read port (1-cycle latency).
module mb_sdp_bram #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
        if (i_re)
            o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/mb_echo_delay.sv
// Sample-rate echo/delay: BRAM ring buffer, wet mix to output and feedback mix back into the buffer.
module mb_echo_delay
    import mb_audio_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     enable,
    input  logic signed [DATA_W-1:0] pcm_in,
    input  logic                     pcm_valid,
    input  logic [ADDR_W-1:0]        delay_len,
    input  logic [2:0]               fb_gain,
    input  logic [2:0]               wet_gain,
    output logic signed [DATA_W-1:0] pcm_out,
    output logic                     pcm_out_valid,
    output logic                     ready,
    output logic                     overrun
);

    echo_state_t               r_state, w_state_nxt;
    logic [ADDR_W-1:0]         r_wr_ptr, r_clear_addr;
    echo_ctx_t                 r_ctx;
    logic signed [DATA_W-1:0]  r_d, r_fbk;

    logic                      w_clear_last, w_accept, w_we;
    logic [ADDR_W-1:0]         w_rd_addr, w_waddr;
    logic [DATA_W-1:0]         w_wdata, w_rd_data;
    logic signed [19:0]        w_wet_prod, w_fbk_prod;
    logic signed [17:0]        w_wet_shr, w_fbk_shr, w_wet_sum, w_fbk_sum;

    assign w_clear_last = (r_clear_addr == {ADDR_W{1'b1}});
    assign w_accept     = (r_state == ST_IDLE) && pcm_valid;
    // delay_len of 0 wraps to wr_ptr itself, the oldest sample in the ring.
    assign w_rd_addr    = r_wr_ptr - delay_len;

    assign w_wet_prod = r_d * $signed({1'b0, r_ctx.wet});
    assign w_fbk_prod = r_d * $signed({1'b0, r_ctx.fb});
    assign w_wet_shr  = 18'(w_wet_prod >>> 3);
    assign w_fbk_shr  = 18'(w_fbk_prod >>> 3);
    assign w_wet_sum  = 18'(r_ctx.x) + w_wet_shr;
    assign w_fbk_sum  = 18'(r_ctx.x) + w_fbk_shr;

    assign w_we    = (r_state == ST_CLEAR) || (r_state == ST_WRITE);
    assign w_waddr = (r_state == ST_CLEAR) ? r_clear_addr : r_wr_ptr;
    assign w_wdata = (r_state == ST_CLEAR) ? '0 : (r_ctx.en ? r_fbk : r_ctx.x);

    mb_sdp_bram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_re    (w_accept),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rd_data)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_CLEAR: if (w_clear_last) w_state_nxt = ST_IDLE;
            ST_IDLE:  if (pcm_valid)    w_state_nxt = ST_READ;
            ST_READ:  w_state_nxt = ST_CALC;
            ST_CALC:  w_state_nxt = ST_WRITE;
            ST_WRITE: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= ST_CLEAR;
            r_wr_ptr      <= '0;
            r_clear_addr  <= '0;
            r_ctx         <= '0;
            r_d           <= '0;
            r_fbk         <= '0;
            pcm_out       <= '0;
            pcm_out_valid <= 1'b0;
            ready         <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            pcm_out_valid <= 1'b0;
            if (pcm_valid && (r_state inside {ST_READ, ST_CALC, ST_WRITE}))
                overrun <= 1'b1;
            case (r_state)
                ST_CLEAR: begin
                    r_clear_addr <= r_clear_addr + 1'b1;
                    if (w_clear_last)
                        ready <= 1'b1;
                    // Dry passthrough while clearing; the sample is not stored.
                    if (pcm_valid) begin
                        pcm_out       <= pcm_in;
                        pcm_out_valid <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (pcm_valid)
                        r_ctx <= '{x: pcm_in, en: enable, fb: fb_gain, wet: wet_gain};
                end
                ST_READ: r_d <= w_rd_data;
                ST_CALC: begin
                    r_fbk         <= pcm_sat(w_fbk_sum);
                    pcm_out       <= r_ctx.en ? pcm_sat(w_wet_sum) : r_ctx.x;
                    pcm_out_valid <= 1'b1;
                end
                ST_WRITE: r_wr_ptr <= r_wr_ptr + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mb_echo_delay.sv
// Directed bench for mb_echo_delay: sample-level echo model, per-cycle compare, literal pins.
module tb_mb_echo_delay;

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic               enable = 1'b0;
    logic signed [15:0] pcm_in = '0;
    logic               pcm_valid = 1'b0;
    logic [13:0]        delay_len = '0;
    logic [2:0]         fb_gain = '0;
    logic [2:0]         wet_gain = '0;
    logic signed [15:0] pcm_out;
    logic               pcm_out_valid;
    logic               ready;
    logic               overrun;

    mb_echo_delay #(.ADDR_W(14), .DATA_W(16)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .enable        (enable),
        .pcm_in        (pcm_in),
        .pcm_valid     (pcm_valid),
        .delay_len     (delay_len),
        .fb_gain       (fb_gain),
        .wet_gain      (wet_gain),
        .pcm_out       (pcm_out),
        .pcm_out_valid (pcm_out_valid),
        .ready         (ready),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int val;
        int due;
    } exp_t;

    exp_t q[$];
    int   mem[16384];
    int   wr = 0;
    int   rel = 0;
    int   busy_until = 0;
    bit   ovr = 1'b0;
    int   ovr_t = 0;
    bit   chk_on = 1'b0;
    int   nvec = 0;
    int   nerr = 0;
    int   last_out = 0;

    function automatic int sat(int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic chk(string name, int act, int expv);
        nvec++;
        if (act != expv) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Drive one strobe and predict its fate: passthrough while clearing, drop while busy, else echo.
    task automatic apply(int x, bit en, int dl, int fb, int wet, int gap);
        int t, d, wv, fv;
        @(negedge clk); #1;
        t         = cyc;
        pcm_in    = 16'(x);
        enable    = en;
        delay_len = 14'(dl);
        fb_gain   = 3'(fb);
        wet_gain  = 3'(wet);
        pcm_valid = 1'b1;
        if (t - rel < 16384) begin
            q.push_back('{x, t + 1});
        end else if (t < busy_until) begin
            if (!ovr) begin
                ovr   = 1'b1;
                ovr_t = t;
            end
        end else begin
            d  = mem[(wr - dl) & 16383];
            wv = sat(x + ((d * wet) >>> 3));
            fv = sat(x + ((d * fb) >>> 3));
            q.push_back('{(en ? wv : x), t + 3});
            mem[wr]    = en ? fv : x;
            wr         = (wr + 1) & 16383;
            busy_until = t + 4;
        end
        @(posedge clk); #1;
        pcm_valid = 1'b0;
        pcm_in    = 16'($urandom);
        enable    = 1'($urandom);
        delay_len = 14'($urandom);
        fb_gain   = 3'($urandom);
        wet_gain  = 3'($urandom);
        repeat (gap - 1) @(posedge clk);
    endtask

    always @(negedge clk) begin
        if (chk_on && rstn) begin
            if (q.size() > 0 && q[0].due == cyc) begin
                chk("strobe", int'(pcm_out_valid), 1);
                chk("pcm_out", int'(pcm_out), q[0].val);
                last_out = int'(pcm_out);
                void'(q.pop_front());
            end else begin
                chk("no_strobe", int'(pcm_out_valid), 0);
            end
            chk("ready", int'(ready), int'(cyc - rel >= 16384));
            chk("overrun", int'(overrun), int'(ovr && cyc > ovr_t));
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("rst_pcm_out", int'(pcm_out), 0);
        chk("rst_valid", int'(pcm_out_valid), 0);
        chk("rst_ready", int'(ready), 0);
        chk("rst_overrun", int'(overrun), 0);
        @(negedge clk); #1;
        rstn   = 1'b1;
        rel    = cyc;
        chk_on = 1'b1;

        for (int i = 0; i < 8; i++) apply(100 * i - 300, 1'b1, 4, 4, 4, 4);
        chk("pin_pass", last_out, 400);
        chk("pin_no_ovr_clear", int'(overrun), 0);
        for (int k = 0; k < 20000 && !ready; k++) @(negedge clk);
        chk("ready_timeout", int'(ready), 1);

        apply(16000, 1'b1, 4, 0, 4, 4);
        chk("pin_impulse", last_out, 16000);
        for (int i = 1; i <= 8; i++) begin
            apply(0, 1'b1, 4, 0, 4, 4);
            if (i == 4) chk("pin_echo_8000", last_out, 8000);
            if (i == 5) chk("pin_after_echo", last_out, 0);
        end

        apply(16000, 1'b1, 4, 4, 7, 4);
        for (int i = 1; i <= 12; i++) begin
            apply(0, 1'b1, 4, 4, 7, 4);
            if (i == 4)  chk("pin_fb_14000", last_out, 14000);
            if (i == 8)  chk("pin_fb_7000", last_out, 7000);
            if (i == 12) chk("pin_fb_3500", last_out, 3500);
        end

        apply(32767, 1'b0, 1, 0, 0, 4);
        apply(30000, 1'b1, 1, 4, 7, 4);
        chk("pin_sat_hi", last_out, 32767);
        apply(-32768, 1'b0, 1, 0, 0, 4);
        apply(-30000, 1'b1, 1, 4, 7, 4);
        chk("pin_sat_lo", last_out, -32768);

        apply(1000, 1'b0, 2, 3, 5, 4);
        apply(2000, 1'b0, 2, 3, 5, 4);
        apply(3000, 1'b0, 2, 3, 5, 4);
        chk("pin_bypass", last_out, 3000);
        apply(0, 1'b1, 3, 0, 4, 4);
        chk("pin_dry_echo", last_out, 500);
        apply(0, 1'b1, 0, 0, 7, 4);

        apply(5000, 1'b1, 2, 0, 4, 2);
        apply(1234, 1'b1, 2, 0, 4, 4);
        apply(0, 1'b1, 1, 0, 0, 4);
        apply(0, 1'b1, 1, 0, 0, 4);
        chk("pin_overrun_sticky", int'(overrun), 1);

        apply(7777, 1'b1, 4, 0, 4, 1);
        rstn = 1'b0;
        q.delete();
        #1;
        chk("midrst_pcm_out", int'(pcm_out), 0);
        chk("midrst_valid", int'(pcm_out_valid), 0);
        chk("midrst_ready", int'(ready), 0);
        chk("midrst_overrun", int'(overrun), 0);
        repeat (3) @(negedge clk);
        chk("hold_valid", int'(pcm_out_valid), 0);
        #1;
        rstn       = 1'b1;
        rel        = cyc;
        ovr        = 1'b0;
        wr         = 0;
        busy_until = 0;
        foreach (mem[i]) mem[i] = 0;
        repeat (40) @(negedge clk);
        chk("post_rst_out", int'(pcm_out), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
